// File: rtl/uart_baud_gen_frac_pkg.sv
// uart_baud_gen_frac_pkg: standard baud table, table index enum and divisor helper
package uart_baud_gen_frac_pkg;

    typedef enum logic [2:0] {
        BAUD_1200,
        BAUD_2400,
        BAUD_4800,
        BAUD_9600,
        BAUD_19200,
        BAUD_38400,
        BAUD_57600,
        BAUD_115200
    } baud_idx_e;

    localparam longint BAUD_TABLE [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

    // Rounded oversample period in 1/2^frac_w cycles, less one whole cycle, so the
    // result reads directly as the packed {div_int, div_frac} pair.
    function automatic longint baud_div(longint clk_hz, longint os, longint baud, int frac_w);
        longint den;
        den = os * baud;
        return ((clk_hz << frac_w) + (den >> 1)) / den - (longint'(1) << frac_w);
    endfunction

endpackage

// File: rtl/uart_baud_gen_frac_div.sv
// uart_baud_gen_frac_div: fractional period divider producing one wrap per oversample period
module uart_baud_gen_frac_div #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick
);

    logic [DIV_W:0]  r_pc;
    logic [FRAC_W-1:0] r_acc;
    logic            r_ext;
    logic [DIV_W:0]  w_term;
    logic [FRAC_W:0] w_sum;

    // One extra bit on the terminal count keeps div_int at full scale plus the carry in range.
    assign w_term = {1'b0, div_int} + {{DIV_W{1'b0}}, r_ext};
    assign w_sum  = {1'b0, r_acc} + {1'b0, div_frac};
    assign tick   = en && !clr && (r_pc == w_term);

    // Period counter; the fractional carry stretches the following period by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc  <= '0;
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (!en || clr) begin
            r_pc  <= '0;
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (tick) begin
            r_pc  <= '0;
            r_acc <= w_sum[FRAC_W-1:0];
            r_ext <= w_sum[FRAC_W];
        end else begin
            r_pc  <= r_pc + (DIV_W+1)'(1);
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: programmable fractional baud generator with oversample and bit ticks
module uart_baud_gen_frac
    import uart_baud_gen_frac_pkg::*;
#(
    parameter longint CLK_FREQ   = 50_000_000,
    parameter int     OVERSAMPLE = 16,
    parameter int     DIV_W      = 16,
    parameter int     FRAC_W     = 4,
    parameter int     RESET_SEL  = int'(BAUD_9600)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_wr,
    input  logic              cfg_mode,
    input  logic [2:0]        cfg_sel,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              tick_os,
    output logic              tick_bit,
    output logic              cfg_pending,
    output logic              active
);

    localparam int CFG_W = DIV_W + FRAC_W;
    localparam int BC_W  = $clog2(OVERSAMPLE);
    localparam logic [CFG_W-1:0] RST_DIV =
        CFG_W'(baud_div(CLK_FREQ, longint'(OVERSAMPLE), BAUD_TABLE[RESET_SEL], FRAC_W));
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(OVERSAMPLE - 1);

    logic [CFG_W-1:0] w_tbl [8];
    logic [CFG_W-1:0] w_dec;
    logic [CFG_W-1:0] r_shadow;
    logic [CFG_W-1:0] r_live;
    logic [BC_W-1:0]  r_bc;
    logic             w_wrap;
    logic             w_apply;
    logic             r_tick_os;
    logic             r_tick_bit;
    logic             r_pending;
    logic             r_active;

    for (genvar g = 0; g < 8; g++) begin : g_tbl
        localparam logic [CFG_W-1:0] C =
            CFG_W'(baud_div(CLK_FREQ, longint'(OVERSAMPLE), BAUD_TABLE[g], FRAC_W));
        assign w_tbl[g] = C;
    end

    // Shadow moves to live only at a period boundary so no period is cut short.
    assign w_dec   = cfg_mode ? {cfg_div_int, cfg_div_frac} : w_tbl[cfg_sel];
    assign w_apply = r_pending && (w_wrap || !en || sync_clr);

    uart_baud_gen_frac_div #(
        .DIV_W (DIV_W),
        .FRAC_W(FRAC_W)
    ) u_div (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .clr     (sync_clr),
        .div_int (r_live[CFG_W-1:FRAC_W]),
        .div_frac(r_live[FRAC_W-1:0]),
        .tick    (w_wrap)
    );

    // Config shadow/live registers; a write arriving with an apply keeps the new value pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shadow  <= RST_DIV;
            r_live    <= RST_DIV;
            r_pending <= 1'b0;
        end else begin
            if (cfg_wr) r_shadow <= w_dec;
            if (w_apply) r_live <= r_shadow;
            r_pending <= cfg_wr || (r_pending && !w_apply);
        end
    end

    // Bit counter and registered tick outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bc       <= '0;
            r_tick_os  <= 1'b0;
            r_tick_bit <= 1'b0;
        end else if (!en || sync_clr) begin
            r_bc       <= '0;
            r_tick_os  <= 1'b0;
            r_tick_bit <= 1'b0;
        end else begin
            r_tick_os  <= w_wrap;
            r_tick_bit <= w_wrap && (r_bc == BC_LAST);
            if (w_wrap) r_bc <= (r_bc == BC_LAST) ? '0 : r_bc + BC_W'(1);
        end
    end

    // Running indicator follows en by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_active <= 1'b0;
        else       r_active <= en;
    end

    assign tick_os     = r_tick_os;
    assign tick_bit    = r_tick_bit;
    assign cfg_pending = r_pending;
    assign active      = r_active;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: directed checks of tick spacing, config apply, sync clear and reset
module tb_uart_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        sync_clr = 1'b0;
    logic        cfg_wr = 1'b0;
    logic        cfg_mode = 1'b0;
    logic [2:0]  cfg_sel = 3'd0;
    logic [15:0] cfg_div_int = 16'd0;
    logic [3:0]  cfg_div_frac = 4'd0;
    logic        tick_os;
    logic        tick_bit;
    logic        cfg_pending;
    logic        active;
    int          vec = 0;
    int          miss = 0;

    always #5 clk = ~clk;

    uart_baud_gen_frac dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .sync_clr    (sync_clr),
        .cfg_wr      (cfg_wr),
        .cfg_mode    (cfg_mode),
        .cfg_sel     (cfg_sel),
        .cfg_div_int (cfg_div_int),
        .cfg_div_frac(cfg_div_frac),
        .tick_os     (tick_os),
        .tick_bit    (tick_bit),
        .cfg_pending (cfg_pending),
        .active      (active)
    );

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_os && n < 2000);
        if (!tick_os) begin
            vec++;
            miss++;
            $display("FAIL tick_timeout: no tick_os within %0d cycles", n);
        end
    endtask

    task automatic write_cfg(input logic mode, input logic [2:0] sel, input logic [15:0] di, input logic [3:0] df);
        cfg_wr = 1'b1;
        cfg_mode = mode;
        cfg_sel = sel;
        cfg_div_int = di;
        cfg_div_frac = df;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        vec++; if (tick_os !== 1'b0) begin miss++; $display("FAIL rst_tick_os: got %b want 0", tick_os); end
        vec++; if (tick_bit !== 1'b0) begin miss++; $display("FAIL rst_tick_bit: got %b want 0", tick_bit); end
        vec++; if (cfg_pending !== 1'b0) begin miss++; $display("FAIL rst_pending: got %b want 0", cfg_pending); end
        vec++; if (active !== 1'b0) begin miss++; $display("FAIL rst_active: got %b want 0", active); end
        rstn = 1'b1;
        @(negedge clk);
        vec++; if (active !== 1'b0) begin miss++; $display("FAIL idle_active: got %b want 0", active); end
    endtask

    task automatic test_table_9600;
        int n;
        int e;
        en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            wait_tick(n);
            if (k <= 5) begin
                e = (k == 1 || k % 2 == 0) ? 325 : 326;
                vec++; if (n !== e) begin miss++; $display("FAIL t9600_gap%0d: got %0d want %0d", k, n, e); end
            end
            vec++; if (tick_bit !== (k % 16 == 0)) begin miss++; $display("FAIL t9600_bit%0d: got %b want %b", k, tick_bit, k % 16 == 0); end
        end
        vec++; if (active !== 1'b1) begin miss++; $display("FAIL run_active: got %b want 1", active); end
    endtask

    task automatic test_prog;
        int n;
        int e [7] = '{4, 4, 5, 4, 5, 4, 5};
        en = 1'b0;
        repeat (2) @(negedge clk);
        vec++; if (tick_os !== 1'b0) begin miss++; $display("FAIL off_tick: got %b want 0", tick_os); end
        vec++; if (active !== 1'b0) begin miss++; $display("FAIL off_active: got %b want 0", active); end
        write_cfg(1'b1, 3'd0, 16'd3, 4'd8);
        vec++; if (cfg_pending !== 1'b1) begin miss++; $display("FAIL off_pend_set: got %b want 1", cfg_pending); end
        @(negedge clk);
        vec++; if (cfg_pending !== 1'b0) begin miss++; $display("FAIL off_pend_clr: got %b want 0", cfg_pending); end
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            wait_tick(n);
            vec++; if (n !== e[k]) begin miss++; $display("FAIL prog_gap%0d: got %0d want %0d", k, n, e[k]); end
        end
    endtask

    task automatic test_table_115200;
        int n;
        int t = 0;
        int s = 0;
        int t1 = -1;
        int t2 = -1;
        en = 1'b0;
        write_cfg(1'b0, 3'd7, 16'd0, 4'd0);
        @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            wait_tick(n);
            t += n;
            if (k >= 2 && k <= 9) s += n;
            if (tick_bit) begin
                if (t1 < 0) t1 = t;
                else t2 = t;
            end
            vec++; if (tick_bit !== (k % 16 == 0)) begin miss++; $display("FAIL b115_bit%0d: got %b want %b", k, tick_bit, k % 16 == 0); end
        end
        vec++; if (s !== 217) begin miss++; $display("FAIL b115_8per: got %0d want 217", s); end
        vec++; if (t1 !== 433) begin miss++; $display("FAIL b115_first_bit: got %0d want 433", t1); end
        vec++; if (t2 - t1 !== 434) begin miss++; $display("FAIL b115_bit_gap: got %0d want 434", t2 - t1); end
    endtask

    task automatic test_midwrite;
        int n;
        int e [5] = '{4, 4, 5, 4, 5};
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        wait_tick(n);
        vec++; if (n !== 27) begin miss++; $display("FAIL mid_first: got %0d want 27", n); end
        write_cfg(1'b1, 3'd0, 16'd3, 4'd8);
        vec++; if (cfg_pending !== 1'b1) begin miss++; $display("FAIL mid_pend_set: got %b want 1", cfg_pending); end
        wait_tick(n);
        vec++; if (n + 1 !== 27) begin miss++; $display("FAIL mid_old_period: got %0d want 27", n + 1); end
        vec++; if (cfg_pending !== 1'b0) begin miss++; $display("FAIL mid_pend_clr: got %b want 0", cfg_pending); end
        for (int k = 0; k < 5; k++) begin
            wait_tick(n);
            vec++; if (n !== e[k]) begin miss++; $display("FAIL mid_gap%0d: got %0d want %0d", k, n, e[k]); end
        end
    endtask

    task automatic test_sync_clr;
        int n;
        en = 1'b0;
        write_cfg(1'b1, 3'd0, 16'd9, 4'd0);
        @(negedge clk);
        en = 1'b1;
        wait_tick(n);
        vec++; if (n !== 10) begin miss++; $display("FAIL sc_first: got %0d want 10", n); end
        repeat (9) @(negedge clk);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        vec++; if (tick_os !== 1'b0) begin miss++; $display("FAIL sc_suppress: got %b want 0", tick_os); end
        wait_tick(n);
        vec++; if (n !== 10) begin miss++; $display("FAIL sc_after: got %0d want 10", n); end
        for (int k = 2; k <= 16; k++) begin
            wait_tick(n);
            vec++; if (tick_bit !== (k == 16)) begin miss++; $display("FAIL sc_bit%0d: got %b want %b", k, tick_bit, k == 16); end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        wait_tick(n);
        #1 rstn = 1'b0;
        #1;
        vec++; if (tick_os !== 1'b0) begin miss++; $display("FAIL amid_tick: got %b want 0", tick_os); end
        vec++; if (active !== 1'b0) begin miss++; $display("FAIL amid_active: got %b want 0", active); end
        en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        vec++; if (cfg_pending !== 1'b0) begin miss++; $display("FAIL amid_pend: got %b want 0", cfg_pending); end
        write_cfg(1'b1, 3'd0, 16'd3, 4'd8);
        @(negedge clk);
        en = 1'b1;
        wait_tick(n);
        vec++; if (n !== 4) begin miss++; $display("FAIL amid_first: got %0d want 4", n); end
    endtask

    initial begin
        test_reset;
        test_table_9600;
        test_prog;
        test_table_115200;
        test_midwrite;
        test_sync_clr;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
